// File: rtl/cla_nibble_seq_if.sv
// Handshake and operand/result bundle for cla_nibble_seq.
// The ovf signal exists only when CLA_NIBBLE_SEQ_OVF_EN is defined.
interface cla_nibble_seq_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef CLA_NIBBLE_SEQ_OVF_EN
    logic         ovf;

    modport master (output in_valid, a, b, cin, out_ready,
                    input  in_ready, out_valid, sum, cout, ovf);
    modport slave  (input  in_valid, a, b, cin, out_ready,
                    output in_ready, out_valid, sum, cout, ovf);
`else
    modport master (output in_valid, a, b, cin, out_ready,
                    input  in_ready, out_valid, sum, cout);
    modport slave  (input  in_valid, a, b, cin, out_ready,
                    output in_ready, out_valid, sum, cout);
`endif
endinterface

// File: rtl/cla_nibble_seq.sv
// W-bit adder that reuses one 4-bit carry-lookahead slice, one nibble per cycle, LSB first.
// Define CLA_NIBBLE_SEQ_OVF_EN to add the registered signed-overflow output.
module cla #(
    parameter int n = 4
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         ci,
    output logic [n-1:0] s,
    output logic         gen,
    output logic         prop
);
    logic [n-1:0] g, p;
    logic         gk, pk, cc;

    // Each bit carry is expanded from the prefix group g/p and ci, not rippled.
    always_comb begin
        g  = a & b;
        p  = a ^ b;
        s  = '0;
        gk = 1'b0;
        pk = 1'b1;
        cc = ci;
        for (int i = 0; i < n; i++) begin
            s[i] = p[i] ^ cc;
            gk   = g[i] | (p[i] & gk);
            pk   = pk & p[i];
            cc   = gk | (pk & ci);
        end
        gen  = gk;
        prop = pk;
    end
endmodule

module cla_nibble_seq #(
    parameter int W = 16
) (
    input logic           clk,
    input logic           rst_n,
    cla_nibble_seq_if.slave bus
);
    localparam int N  = W / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [W-1:0]  a_q, b_q, sum_q;
    logic          carry_reg, cout_q, in_ready_q, out_valid_q;
    logic [IW-1:0] idx;
    logic [3:0]    a_nib, b_nib, s;
    logic          gen, prop, cout_next, last;

    assign a_nib     = a_q[{idx, 2'b00} +: 4];
    assign b_nib     = b_q[{idx, 2'b00} +: 4];
    assign cout_next = gen | (prop & carry_reg);
    assign last      = (idx == IW'(N - 1));

    cla #(.n(4)) u_cla (
        .a    (a_nib),
        .b    (b_nib),
        .ci   (carry_reg),
        .s    (s),
        .gen  (gen),
        .prop (prop)
    );

`ifdef CLA_NIBBLE_SEQ_OVF_EN
    logic ovf_q;
    assign bus.ovf = ovf_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_reg   <= 1'b0;
            cout_q      <= 1'b0;
            idx         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef CLA_NIBBLE_SEQ_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    a_q        <= bus.a;
                    b_q        <= bus.b;
                    carry_reg  <= bus.cin;
                    idx        <= '0;
                    in_ready_q <= 1'b0;
                    state      <= RUN;
                end
                RUN: begin
                    sum_q[{idx, 2'b00} +: 4] <= s;
                    carry_reg                <= cout_next;
                    if (last) begin
                        cout_q      <= cout_next;
`ifdef CLA_NIBBLE_SEQ_OVF_EN
                        // s[3]^a^b recovers the carry into the MSB.
                        ovf_q       <= cout_next ^ (s[3] ^ a_q[W-1] ^ b_q[W-1]);
`endif
                        idx         <= '0;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
endmodule

// File: doc/cla_nibble_seq.md
# cla_nibble_seq

Multi-cycle wide adder controller that sequences one shared 4-bit `cla` slice across a W-bit operand pair, one nibble per cycle, LSB nibble first. It registers the inter-nibble carry from the slice's group generate/propagate outputs. Valid/ready handshakes on both sides let it sit between a requester and a consumer wherever area matters more than latency.

## Interface
Parameters:
- `W`, 16: operand width. Must be a multiple of 4 and ≥ 4. N = W/4 nibble steps.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: operands valid.
- `in_ready`, output, 1: block can accept operands.
- `a`, input, W: operand A.
- `b`, input, W: operand B.
- `cin`, input, 1: carry-in.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: consumer accepts result.
- `sum`, output, W: A+B+cin, modulo 2^W.
- `cout`, output, 1: carry out of bit W-1.
- `ovf`, output, 1: signed overflow. Present only with `CLA_NIBBLE_SEQ_OVF_EN`.

## Operation
- Exactly one `cla` instance (n=4) inside. The nibble carry-out is `gen | (prop & carry_reg)`.
- Registers: `a_q`, `b_q` (W), `carry_reg`, `idx` (clog2(N), min 1 bit), `sum_q`, `cout_q`, `state`.
- FSM states:
  - IDLE:
    - `in_ready`=1.
    - On `in_valid`, latch a, b and cin: `carry_reg`←cin, `idx`←0, go to RUN.
  - RUN:
    - Slice inputs are nibble `idx` of `a_q`/`b_q` plus `carry_reg`.
    - Each cycle: `sum_q[4*idx+:4]`←s, `carry_reg`←nibble carry-out, `idx`←idx+1.
    - When `idx`=N-1: `cout_q`←carry-out, go to DONE.
  - DONE:
    - `out_valid`=1.
    - `sum`, `cout` and `ovf` are held stable.
    - On `out_ready`, go to IDLE.
- `in_ready` is 1 only in IDLE. While `in_ready`=0, `in_valid` and the operand inputs are ignored.
- The result ports are only meaningful while `out_valid`=1. During RUN they show partial accumulation.
- After DONE, the ports hold the last result until the next acceptance.
- `idx` never wraps mid-operation. For N=1, RUN lasts exactly one cycle.

## Timing
- Reset (async assert, clock-synchronous deassert by the environment):
  - state=IDLE, `sum`=0, `cout`=0, `ovf`=0, `out_valid`=0.
  - `in_ready` reads 1 in IDLE. No transfer is taken while `rst_n`=0.
- Acceptance at edge E0. RUN occupies edges E0+1 … E0+N.
- `out_valid` is high in the cycle after edge E0+N, i.e. latency N cycles from acceptance.
- With `out_ready` held at 1: DONE lasts 1 cycle, then IDLE lasts 1 cycle. Minimum initiation interval is N+2 cycles (6 for W=16).
- `out_ready` asserted while `out_valid`=0 has no effect.
- Reset mid-RUN or mid-DONE: the operation is aborted and the result is not delivered. All outputs return to their reset values immediately, with no pending state carried over.
- Combinational path per cycle: one 4-bit `cla` plus the carry-merge gate. There is no path from `in_*` to `out_*`.

## Configuration
- `CLA_NIBBLE_SEQ_OVF_EN` defined:
  - `ovf` port exists.
  - On the last RUN cycle, `ovf`←`cout_next ^ (s[3]^a_q[W-1]^b_q[W-1])` (carry-out XOR carry into the MSB).
  - Held and reset like `cout`.
- Macro undefined: no `ovf` port and no overflow register. All other behaviour is identical.

## Test plan
- Basic add, W=16: a=0x1234, b=0x4321, cin=0 → `out_valid` exactly 4 cycles after acceptance, `sum`=0x5555, `cout`=0, `ovf`=0.
- Full ripple: a=0xFFFF, b=0x0001, cin=0 → `sum`=0x0000, `cout`=1, `ovf`=0. Then a=0x0000, b=0x0000, cin=1 → `sum`=0x0001, `cout`=0.
- Signed overflow (macro on): a=0x7FFF, b=0x0001 → `sum`=0x8000, `cout`=0, `ovf`=1. Then a=0x8000, b=0x8000 → `sum`=0x0000, `cout`=1, `ovf`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` rises, with `in_valid`=1 and changing operands.
  - `out_valid`, `sum` and `cout` stay stable; `in_ready`=0; the new operands are not captured.
  - After `out_ready`=1, the next accept occurs 2 cycles later.
- Back-to-back: 20 random operand pairs with `in_valid` and `out_ready` tied high → each result matches the reference sum, and accepts are spaced exactly 6 cycles apart.
- Reset mid-operation: assert `rst_n`=0 two cycles into RUN → outputs go to 0 and `out_valid`=0 immediately. After release, a=0x00FF, b=0x0F01 → `sum`=0x1000, `cout`=0.
